// File: rtl/rnl_neuron.sv
// rnl_neuron: race-logic (ramp-no-leak) spiking neuron with a weight write port.
//
// Operation: a start pulse in IDLE latches one spike time per input. The
// neuron then steps time t = 0, 1, ... and adds one unit per cycle for every
// input whose ramp is active. It fires when the body potential reaches
// THRESHOLD. If t reaches TMAX without firing, it reports no spike.
//
// Optional feature: define RNL_NEURON_STDP_EN to add a one-cycle UPDATE state
// after RUN. After a firing cycle, UPDATE applies a saturating +/-1 STDP rule
// to each weight.
//
// Ports:
//   clk           - clock, rising edge
//   rst_l         - asynchronous active-low reset
//   start         - begin a gamma cycle (honoured in IDLE only)
//   spike_time_in - per-input spike times, all-ones = no spike, sampled on start
//   w_wr_en       - weight write strobe (honoured in IDLE only)
//   w_wr_idx      - weight write index (out-of-range indices ignored)
//   w_wr_data     - weight write value
//   busy          - high in every state except IDLE
//   done          - one-cycle pulse when a result is available
//   fired         - last gamma cycle crossed threshold
//   out_time      - output spike time, all-ones when not fired
//   weights_out   - current weight registers
module rnl_neuron #(
    parameter int unsigned NUM_IN    = 8,
    parameter int unsigned WBITS     = 3,
    parameter int unsigned TBITS     = 4,
    parameter int unsigned THRESHOLD = 8
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             start,
    input  logic [NUM_IN-1:0][TBITS-1:0]     spike_time_in,
    input  logic                             w_wr_en,
    input  logic [$clog2(NUM_IN)-1:0]        w_wr_idx,
    input  logic [WBITS-1:0]                 w_wr_data,
    output logic                             busy,
    output logic                             done,
    output logic                             fired,
    output logic [TBITS-1:0]                 out_time,
    output logic [NUM_IN-1:0][WBITS-1:0]     weights_out
);

    localparam int unsigned WMAX_I = (1 << WBITS) - 1;
    localparam int unsigned PW     = $clog2(NUM_IN * WMAX_I + 1);

    localparam logic [TBITS-1:0] TNONE = '1;
    localparam logic [TBITS-1:0] TMAX  = TBITS'((1 << TBITS) - 2);
    localparam logic [WBITS-1:0] WMAX  = '1;

    // One extra bit so that s_i + w_i never wraps.
    typedef logic [TBITS:0] text_t;

    typedef enum logic [1:0] {StIdle, StRun, StUpdate, StDone} state_t;

    state_t                          state_q, state_d;
    logic [TBITS-1:0]                t_q, t_d;
    logic [PW-1:0]                   pot_q, pot_d;
    logic [NUM_IN-1:0][TBITS-1:0]    spk_q, spk_d;
    logic [NUM_IN-1:0][WBITS-1:0]    w_q, w_d;
    // Snapshot of the weights at start, so a same-cycle write cannot affect
    // the gamma cycle that it overlaps.
    logic [NUM_IN-1:0][WBITS-1:0]    wrun_q, wrun_d;
    logic                            fired_q, fired_d;
    logic [TBITS-1:0]                out_time_q, out_time_d;

    logic [PW-1:0]                   inc;
    logic [PW-1:0]                   pot_sum;

    // Number of inputs whose ramp is active at the current time step.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (spk_q[i] != TNONE && spk_q[i] <= t_q &&
                text_t'(t_q) < text_t'(spk_q[i]) + text_t'(wrun_q[i])) begin
                inc = inc + PW'(1);
            end
        end
        pot_sum = pot_q + inc;
    end

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        pot_d      = pot_q;
        spk_d      = spk_q;
        w_d        = w_q;
        wrun_d     = wrun_q;
        fired_d    = fired_q;
        out_time_d = out_time_q;

        unique case (state_q)
            StIdle: begin
                if (w_wr_en && 32'(w_wr_idx) < NUM_IN) begin
                    w_d[w_wr_idx] = w_wr_data;
                end
                if (start) begin
                    spk_d   = spike_time_in;
                    wrun_d  = w_q;
                    t_d     = '0;
                    pot_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                pot_d = pot_sum;
                if (32'(pot_sum) >= THRESHOLD) begin
                    fired_d    = 1'b1;
                    out_time_d = t_q;
`ifdef RNL_NEURON_STDP_EN
                    state_d    = StUpdate;
`else
                    state_d    = StDone;
`endif
                end else if (t_q == TMAX) begin
                    fired_d    = 1'b0;
                    out_time_d = TNONE;
`ifdef RNL_NEURON_STDP_EN
                    state_d    = StUpdate;
`else
                    state_d    = StDone;
`endif
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
`ifdef RNL_NEURON_STDP_EN
            StUpdate: begin
                // Causal inputs (at or before the output spike) strengthen,
                // late inputs weaken, silent inputs are left alone.
                if (fired_q) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (spk_q[i] != TNONE) begin
                            if (spk_q[i] <= out_time_q) begin
                                if (w_q[i] != WMAX) w_d[i] = w_q[i] + 1'b1;
                            end else begin
                                if (w_q[i] != '0) w_d[i] = w_q[i] - 1'b1;
                            end
                        end
                    end
                end
                state_d = StDone;
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= StIdle;
            t_q        <= '0;
            pot_q      <= '0;
            spk_q      <= '0;
            w_q        <= '0;
            wrun_q     <= '0;
            fired_q    <= 1'b0;
            out_time_q <= TNONE;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pot_q      <= pot_d;
            spk_q      <= spk_d;
            w_q        <= w_d;
            wrun_q     <= wrun_d;
            fired_q    <= fired_d;
            out_time_q <= out_time_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign fired       = fired_q;
    assign out_time    = out_time_q;
    assign weights_out = w_q;

endmodule

// File: tb/tb_rnl_neuron.sv
// tb_rnl_neuron: directed self-checking bench for rnl_neuron
// (NUM_IN=4, WBITS=3, TBITS=4, THRESHOLD=6). It follows RNL_NEURON_STDP_EN
// when that macro is defined for the build.
module tb_rnl_neuron;

`ifdef RNL_NEURON_STDP_EN
    localparam int EXTRA = 1;
    localparam bit STDP  = 1'b1;
`else
    localparam int EXTRA = 0;
    localparam bit STDP  = 1'b0;
`endif

    logic             clk;
    logic             rst_l;
    logic             start;
    logic [3:0][3:0]  spike_time_in;
    logic             w_wr_en;
    logic [1:0]       w_wr_idx;
    logic [2:0]       w_wr_data;
    logic             busy;
    logic             done;
    logic             fired;
    logic [3:0]       out_time;
    logic [3:0][2:0]  weights_out;

    int n_checks = 0;
    int n_pass   = 0;

    rnl_neuron #(
        .NUM_IN   (4),
        .WBITS    (3),
        .TBITS    (4),
        .THRESHOLD(6)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .start        (start),
        .spike_time_in(spike_time_in),
        .w_wr_en      (w_wr_en),
        .w_wr_idx     (w_wr_idx),
        .w_wr_data    (w_wr_data),
        .busy         (busy),
        .done         (done),
        .fired        (fired),
        .out_time     (out_time),
        .weights_out  (weights_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wr(input logic [1:0] idx, input logic [2:0] data);
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_idx  = idx;
        w_wr_data = data;
        @(negedge clk);
        w_wr_en   = 1'b0;
    endtask

    task automatic wr_all(input logic [2:0] data);
        for (int i = 0; i < 4; i++) wr(2'(i), data);
    endtask

    // Launch one gamma cycle and check its latency and result. Latency counts
    // cycles after the start cycle (first negedge after the sampling edge = 1).
    // With poke set, a start pulse and a write to weight 1 are driven mid-run.
    task automatic run_gamma(input string tag, input logic [15:0] sp, input logic wr_en,
                             input logic [1:0] wr_idx, input logic [2:0] wr_data,
                             input bit poke, input int exp_lat, input logic exp_fired,
                             input logic [3:0] exp_time);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        start         = 1'b1;
        spike_time_in = sp;
        w_wr_en       = wr_en;
        w_wr_idx      = wr_idx;
        w_wr_data     = wr_data;
        @(posedge clk);
        #1;
        start         = 1'b0;
        w_wr_en       = 1'b0;
        spike_time_in = '0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin
                check({tag, " busy mid-run"}, 32'(busy), 1);
                start         = 1'b1;
                spike_time_in = '0;
                w_wr_en       = 1'b1;
                w_wr_idx      = 2'd1;
                w_wr_data     = 3'd5;
            end
            if (poke && i == 4) begin
                start   = 1'b0;
                w_wr_en = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " fired"}, 32'(fired), 32'(exp_fired));
        check({tag, " out_time"}, 32'(out_time), 32'(exp_time));
        @(negedge clk);
        check({tag, " idle after done"}, 32'(busy), 0);
    endtask

    initial begin
        int dcount;
        rst_l         = 1'b1;
        start         = 1'b0;
        spike_time_in = '0;
        w_wr_en       = 1'b0;
        w_wr_idx      = '0;
        w_wr_data     = '0;

        // Reset state.
        #2 rst_l = 1'b0;
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst fired", 32'(fired), 0);
        check("rst out_time", 32'(out_time), 15);
        check("rst weights", 32'(weights_out), 0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        // Strong weights, two early inputs: pot 2, 4, 6 -> fires at t=2.
        wr_all(3'd7);
        check("wr all 7", 32'(weights_out), 'hFFF);
        run_gamma("w7", 16'hFF00, 1'b0, 2'd0, 3'd0, 1'b0, 4 + EXTRA, 1'b1, 4'd2);
        check("w7 weights", 32'(weights_out), 'hFFF);

        // Unit weights, all at t=0: pot stays 4, times out at TMAX=14.
        wr_all(3'd1);
        check("wr all 1", 32'(weights_out), 'h249);
        run_gamma("w1", 16'h0000, 1'b0, 2'd0, 3'd0, 1'b0, 16 + EXTRA, 1'b0, 4'd15);
        check("w1 weights", 32'(weights_out), 'h249);

        // No spikes at all.
        run_gamma("silent", 16'hFFFF, 1'b0, 2'd0, 3'd0, 1'b0, 16 + EXTRA, 1'b0, 4'd15);
        check("silent weights", 32'(weights_out), 'h249);

        // Weights 3, spikes {0,1,5,15}: pot 1, 3, 5, 6 -> fires at t=3.
        wr_all(3'd3);
        run_gamma("w3", 16'hF510, 1'b0, 2'd0, 3'd0, 1'b0, 5 + EXTRA, 1'b1, 4'd3);
        check("w3 weights", 32'(weights_out), STDP ? 'h6A4 : 'h6DB);

        // Write alongside start: write lands, run still uses old weight 7.
        wr_all(3'd7);
        run_gamma("wr+start", 16'hFF00, 1'b1, 2'd0, 3'd0, 1'b0, 4 + EXTRA, 1'b1, 4'd2);
        check("wr+start weights", 32'(weights_out), STDP ? 'hFF9 : 'hFF8);

        // Start pulse and write while busy are both ignored.
        run_gamma("poke", 16'hFFFF, 1'b0, 2'd0, 3'd0, 1'b1, 16 + EXTRA, 1'b0, 4'd15);
        check("poke weights", 32'(weights_out), STDP ? 'hFF9 : 'hFF8);
        wr(2'd1, 3'd5);
        check("idle wr w1", 32'(weights_out[1]), 5);

        // Reset mid-RUN after a firing cycle.
        wr_all(3'd7);
        run_gamma("pre-rst", 16'hFF00, 1'b0, 2'd0, 3'd0, 1'b0, 4 + EXTRA, 1'b1, 4'd2);
        @(negedge clk);
        start         = 1'b1;
        spike_time_in = 16'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-rst busy", 32'(busy), 1);
        rst_l = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 0);
        check("midrst fired", 32'(fired), 0);
        check("midrst out_time", 32'(out_time), 15);
        check("midrst weights", 32'(weights_out), 0);
        @(negedge clk);
        rst_l  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst no done", 32'(dcount), 0);
        check("midrst idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
